// File: rtl/conv_bram_1d_engine_if.sv
// rtl/conv_bram_1d_engine_if.sv - image read port and result write port of the 1-D convolution engine
interface conv_bram_1d_engine_if #(
    parameter int DATA_WIDTH            = 8,
    parameter int IMG_D                 = 8,
    parameter int IMG_RAM_ADDR_WIDTH    = 5,
    parameter int RESULT_RAM_ADDR_WIDTH = 8
);
    logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr;
    logic                             img_rden;
    logic [DATA_WIDTH*IMG_D-1:0]      img_rddata;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] result_wraddr;
    logic [DATA_WIDTH-1:0]            result_wrdata;
    logic                             result_wren;
    logic                             last_val;

    // engine side: drives the image read request and the result writes
    modport master (
        output img_rdaddr, img_rden,
        input  img_rddata,
        output result_wraddr, result_wrdata, result_wren, last_val
    );

    // memory side: answers image reads one cycle later and absorbs result writes
    modport slave (
        input  img_rdaddr, img_rden,
        output img_rddata,
        input  result_wraddr, result_wrdata, result_wren, last_val
    );
endinterface

// File: rtl/conv_bram_1d_engine.sv
// rtl/conv_bram_1d_engine.sv - 1-D convolution engine over a column-addressed image BRAM
module conv_bram_1d_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_D      = 8,
    parameter int FILTER_L   = 3,
    parameter int RESULT_D   = 8,
    parameter int STRIDE_W   = 1,
    parameter int PAD_W      = 0,
    parameter int MAC_LAT    = 3,
    parameter int RELU_EN    = 0,
    localparam int RESULT_W              = (IMG_W + 2*PAD_W - FILTER_L) / STRIDE_W + 1,
    localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W*RESULT_D)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    input  logic [DATA_WIDTH*IMG_D*FILTER_L*RESULT_D-1:0] fil,
    conv_bram_1d_engine_if.master bus
);
    localparam int COL_W     = DATA_WIDTH*IMG_D;
    localparam int PAD_TOTAL = IMG_W + 2*PAD_W;
    localparam int P_BITS    = $clog2(PAD_TOTAL + 1);
    localparam int FETCH_MAX = (FILTER_L > STRIDE_W) ? FILTER_L : STRIDE_W;
    localparam int F_BITS    = $clog2(FETCH_MAX + 1);
    localparam int J_BITS    = $clog2(RESULT_W + 1);
    localparam int K_BITS    = $clog2(RESULT_D + 1);
    localparam int MUL_W     = 2*DATA_WIDTH;
    localparam int ACC_W     = 2*DATA_WIDTH + $clog2(IMG_D*FILTER_L);
    localparam int IA        = IMG_RAM_ADDR_WIDTH;
    localparam int RA        = RESULT_RAM_ADDR_WIDTH;

    localparam logic [F_BITS-1:0] FILL_CNT  = F_BITS'(FILTER_L);
    localparam logic [F_BITS-1:0] STEP_CNT  = F_BITS'(STRIDE_W);
    localparam logic [J_BITS-1:0] J_LAST    = J_BITS'(RESULT_W - 1);
    localparam logic [K_BITS-1:0] K_LAST    = K_BITS'(RESULT_D - 1);
    localparam logic [RA-1:0]     LAST_ADDR = RA'(RESULT_W*RESULT_D - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_WIDTH-1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [P_BITS-1:0]   p_q, p_d;
    logic [F_BITS-1:0]   fetch_left_q, fetch_left_d;
    logic [J_BITS-1:0]   j_q, j_d;
    logic [K_BITS-1:0]   k_q, k_d;
    logic [RA-1:0]       addr_q, addr_d;
    logic                rden_q, rden_d;
    logic [IA-1:0]       rdaddr_q, rdaddr_d;
    logic                fetch_q, fetch_d;
    logic                fetch_pad_q, fetch_pad_d;
    logic                arr_q, arr_pad_q;
    logic                issue;
    int                  pcol;

    logic [COL_W-1:0]    window_q [FILTER_L];

    logic signed [MUL_W-1:0]      px, wt, prod;
    logic signed [ACC_W-1:0]      acc;
    logic [DATA_WIDTH-1:0]        sat_val, res_val;

    logic                  v_pipe_q [MAC_LAT];
    logic [DATA_WIDTH-1:0] d_pipe_q [MAC_LAT];
    logic [RA-1:0]         a_pipe_q [MAC_LAT];

    logic out_last;

    assign out_last = v_pipe_q[MAC_LAT-1] && (a_pipe_q[MAC_LAT-1] == LAST_ADDR);

    // next-state: column fetch sequencing, per-filter issue and run completion
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        fetch_left_d = fetch_left_q;
        j_d          = j_q;
        k_d          = k_q;
        addr_d       = addr_q;
        rdaddr_d     = rdaddr_q;
        rden_d       = 1'b0;
        fetch_d      = 1'b0;
        fetch_pad_d  = 1'b0;
        issue        = 1'b0;
        pcol         = int'(p_q) - PAD_W;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_FILL;
                    p_d          = '0;
                    fetch_left_d = FILL_CNT;
                    j_d          = '0;
                    k_d          = '0;
                    addr_d       = '0;
                end
            end
            S_FILL: begin
                if (fetch_left_q != '0) begin
                    fetch_d      = 1'b1;
                    fetch_left_d = fetch_left_q - 1'b1;
                    p_d          = p_q + 1'b1;
                    if (pcol >= 0 && pcol < IMG_W) begin
                        rden_d   = 1'b1;
                        rdaddr_d = IA'(pcol);
                    end else begin
                        fetch_pad_d = 1'b1;
                    end
                end else if (!fetch_q && !arr_q) begin
                    // every requested column has landed in the window
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                issue  = 1'b1;
                addr_d = addr_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (j_q == J_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        j_d          = j_q + 1'b1;
                        fetch_left_d = STEP_CNT;
                        state_d      = S_FILL;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            p_q          <= '0;
            fetch_left_q <= '0;
            j_q          <= '0;
            k_q          <= '0;
            addr_q       <= '0;
            rden_q       <= 1'b0;
            rdaddr_q     <= '0;
            fetch_q      <= 1'b0;
            fetch_pad_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            fetch_left_q <= fetch_left_d;
            j_q          <= j_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            rden_q       <= rden_d;
            rdaddr_q     <= rdaddr_d;
            fetch_q      <= fetch_d;
            fetch_pad_q  <= fetch_pad_d;
        end
    end

    // column window: shift in read data (or a zero pad column) the cycle it arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            arr_q     <= 1'b0;
            arr_pad_q <= 1'b0;
            for (int t = 0; t < FILTER_L; t++) begin
                window_q[t] <= '0;
            end
        end else begin
            arr_q     <= fetch_q;
            arr_pad_q <= fetch_pad_q;
            if (arr_q) begin
                for (int t = 0; t < FILTER_L - 1; t++) begin
                    window_q[t] <= window_q[t+1];
                end
                window_q[FILTER_L-1] <= arr_pad_q ? '0 : bus.img_rddata;
            end
        end
    end

    // full-precision dot product of the window with filter k, then saturate and optional ReLU
    always_comb begin
        acc  = '0;
        px   = '0;
        wt   = '0;
        prod = '0;
        for (int t = 0; t < FILTER_L; t++) begin
            for (int c = 0; c < IMG_D; c++) begin
                px   = MUL_W'($signed(window_q[t][c*DATA_WIDTH +: DATA_WIDTH]));
                wt   = MUL_W'($signed(fil[((int'(k_q)*FILTER_L + t)*IMG_D + c)*DATA_WIDTH +: DATA_WIDTH]));
                prod = px * wt;
                acc  = acc + ACC_W'(prod);
            end
        end
        if (acc > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = acc[DATA_WIDTH-1:0];
        end
        res_val = sat_val;
        if (RELU_EN != 0 && sat_val[DATA_WIDTH-1]) begin
            res_val = '0;
        end
    end

    // result pipeline: valid, address and data travel together for MAC_LAT cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                v_pipe_q[i] <= 1'b0;
                d_pipe_q[i] <= '0;
                a_pipe_q[i] <= '0;
            end
        end else begin
            v_pipe_q[0] <= issue;
            d_pipe_q[0] <= res_val;
            a_pipe_q[0] <= addr_q;
            for (int i = 1; i < MAC_LAT; i++) begin
                v_pipe_q[i] <= v_pipe_q[i-1];
                d_pipe_q[i] <= d_pipe_q[i-1];
                a_pipe_q[i] <= a_pipe_q[i-1];
            end
        end
    end

    assign bus.img_rden      = rden_q;
    assign bus.img_rdaddr    = rdaddr_q;
    assign bus.result_wren   = v_pipe_q[MAC_LAT-1];
    assign bus.result_wrdata = d_pipe_q[MAC_LAT-1];
    assign bus.result_wraddr = a_pipe_q[MAC_LAT-1];
    assign bus.last_val      = out_last;

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_conv_bram_1d_engine.sv
// tb/tb_conv_bram_1d_engine.sv - directed self-checking bench for conv_bram_1d_engine
module tb_conv_bram_1d_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst;
    logic [3:0]  st;
    wire  [3:0]  busy;
    wire  [3:0]  done;
    logic [23:0] fil_a, fil_b, fil_d;
    logic [47:0] fil_c;
    logic [7:0]  mem [4][8];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_w[4], n_rd[4], lv_cyc[4], done_cyc[4];
    logic [2:0] w_addr [4][16];
    logic [7:0] w_data [4][16];
    logic       w_lv   [4][16];

    conv_bram_1d_engine_if #(.DATA_WIDTH(8), .IMG_D(1), .IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(3)) if_a ();
    conv_bram_1d_engine_if #(.DATA_WIDTH(8), .IMG_D(1), .IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(3)) if_b ();
    conv_bram_1d_engine_if #(.DATA_WIDTH(8), .IMG_D(1), .IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(3)) if_c ();
    conv_bram_1d_engine_if #(.DATA_WIDTH(8), .IMG_D(1), .IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(3)) if_d ();

    conv_bram_1d_engine #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(1), .FILTER_L(3), .RESULT_D(1),
        .STRIDE_W(1), .PAD_W(0), .MAC_LAT(3), .RELU_EN(0)) dut_a (
        .clk(clk), .reset(rst[0]), .start(st[0]), .busy(busy[0]), .done(done[0]), .fil(fil_a), .bus(if_a.master));
    conv_bram_1d_engine #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(1), .FILTER_L(3), .RESULT_D(1),
        .STRIDE_W(1), .PAD_W(1), .MAC_LAT(1), .RELU_EN(0)) dut_b (
        .clk(clk), .reset(rst[1]), .start(st[1]), .busy(busy[1]), .done(done[1]), .fil(fil_b), .bus(if_b.master));
    conv_bram_1d_engine #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(1), .FILTER_L(3), .RESULT_D(2),
        .STRIDE_W(2), .PAD_W(0), .MAC_LAT(2), .RELU_EN(0)) dut_c (
        .clk(clk), .reset(rst[2]), .start(st[2]), .busy(busy[2]), .done(done[2]), .fil(fil_c), .bus(if_c.master));
    conv_bram_1d_engine #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(1), .FILTER_L(3), .RESULT_D(1),
        .STRIDE_W(1), .PAD_W(0), .MAC_LAT(3), .RELU_EN(1)) dut_d (
        .clk(clk), .reset(rst[3]), .start(st[3]), .busy(busy[3]), .done(done[3]), .fil(fil_d), .bus(if_d.master));

    always @(posedge clk) cyc <= cyc + 1;

    // image BRAM models: one-cycle read latency
    always @(posedge clk) if (if_a.img_rden) if_a.img_rddata <= mem[0][if_a.img_rdaddr];
    always @(posedge clk) if (if_b.img_rden) if_b.img_rddata <= mem[1][if_b.img_rdaddr];
    always @(posedge clk) if (if_c.img_rden) if_c.img_rddata <= mem[2][if_c.img_rdaddr];
    always @(posedge clk) if (if_d.img_rden) if_d.img_rddata <= mem[3][if_d.img_rdaddr];

    task automatic mon(input int u, input logic wren, input logic [2:0] a, input logic [7:0] d,
                       input logic lv, input logic dn, input logic rd);
        if (wren) begin
            if (n_w[u] < 16) begin
                w_addr[u][n_w[u]] = a;
                w_data[u][n_w[u]] = d;
                w_lv[u][n_w[u]]   = lv;
            end
            n_w[u]++;
        end
        if (lv) lv_cyc[u] = cyc;
        if (dn) done_cyc[u] = cyc;
        if (rd) n_rd[u]++;
    endtask

    always @(negedge clk) mon(0, if_a.result_wren, if_a.result_wraddr, if_a.result_wrdata, if_a.last_val, done[0], if_a.img_rden);
    always @(negedge clk) mon(1, if_b.result_wren, if_b.result_wraddr, if_b.result_wrdata, if_b.last_val, done[1], if_b.img_rden);
    always @(negedge clk) mon(2, if_c.result_wren, if_c.result_wraddr, if_c.result_wrdata, if_c.last_val, done[2], if_c.img_rden);
    always @(negedge clk) mon(3, if_d.result_wren, if_d.result_wraddr, if_d.result_wrdata, if_d.last_val, done[3], if_d.img_rden);

    task automatic clear_unit(input int u);
        n_w[u] = 0; n_rd[u] = 0; lv_cyc[u] = -1; done_cyc[u] = -1;
        for (int i = 0; i < 16; i++) begin
            w_addr[u][i] = 3'd0; w_data[u][i] = 8'h55; w_lv[u][i] = 1'b0;
        end
    endtask

    task automatic pulse_start(input int u);
        @(posedge clk); #1 st[u] = 1'b1;
        @(posedge clk); #1 st[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input string tag);
        for (int i = 0; i < 400 && done_cyc[u] < 0; i++) @(posedge clk);
        checks++;
        if (done_cyc[u] < 0) begin
            errors++;
            $display("FAIL %s_timeout: done pulse absent after 400 cycles, required a done pulse", tag);
        end
        @(negedge clk);
    endtask

    task automatic fill_mem(input int u, input logic [7:0] v);
        for (int i = 0; i < 8; i++) mem[u][i] = v;
    endtask

    task automatic test_reset;
        rst = 4'hF; st = 4'h0;
        fil_a = '0; fil_b = '0; fil_c = '0; fil_d = '0;
        for (int u = 0; u < 4; u++) begin fill_mem(u, 8'd0); clear_unit(u); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 8'h00) begin
            errors++; $display("FAIL reset_busy_done: got %b, required 00000000", {busy, done});
        end
        checks++;
        if ({if_a.img_rden, if_a.result_wren, if_a.last_val} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes_a: got %b, required 000", {if_a.img_rden, if_a.result_wren, if_a.last_val});
        end
        checks++;
        if ({if_a.img_rdaddr, if_a.result_wraddr, if_a.result_wrdata} !== 14'h0) begin
            errors++; $display("FAIL reset_buses_a: got %h, required 0000", {if_a.img_rdaddr, if_a.result_wraddr, if_a.result_wrdata});
        end
        checks++;
        if ({if_b.img_rden, if_b.result_wren, if_b.last_val, if_c.img_rden, if_c.result_wren, if_c.last_val,
             if_d.img_rden, if_d.result_wren, if_d.last_val} !== 9'h0) begin
            errors++; $display("FAIL reset_strobes_bcd: got %b, required 000000000",
                {if_b.img_rden, if_b.result_wren, if_b.last_val, if_c.img_rden, if_c.result_wren, if_c.last_val,
                 if_d.img_rden, if_d.result_wren, if_d.last_val});
        end
        @(posedge clk); #1 rst = 4'h0;
    endtask

    task automatic test_basic;
        fill_mem(0, 8'd1); fil_a = {3{8'd1}};
        clear_unit(0); pulse_start(0); wait_done(0, "basic");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL basic_count: got %0d writes, required 6", n_w[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_addr[0][i] !== 3'(i) || w_data[0][i] !== 8'd3 || w_lv[0][i] !== (i == 5)) begin
                errors++;
                $display("FAIL basic_write[%0d]: addr=%0d data=%0d last=%b, required addr=%0d data=3 last=%b",
                    i, w_addr[0][i], $signed(w_data[0][i]), w_lv[0][i], i, (i == 5));
            end
        end
        checks++;
        if (done_cyc[0] !== lv_cyc[0] + 1) begin
            errors++; $display("FAIL basic_done_timing: done at %0d, required %0d", done_cyc[0], lv_cyc[0] + 1);
        end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_after_done: got %b, required 0", busy[0]); end
        checks++;
        if (n_rd[0] !== 8) begin errors++; $display("FAIL basic_reads: got %0d, required 8", n_rd[0]); end
    endtask

    task automatic test_ramp;
        for (int i = 0; i < 8; i++) mem[0][i] = 8'(i + 1);
        fil_a = {3{8'd1}};
        clear_unit(0); pulse_start(0); wait_done(0, "ramp");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL ramp_count: got %0d, required 6", n_w[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_addr[0][i] !== 3'(i) || w_data[0][i] !== 8'(3*i + 6)) begin
                errors++;
                $display("FAIL ramp_write[%0d]: addr=%0d data=%0d, required addr=%0d data=%0d",
                    i, w_addr[0][i], $signed(w_data[0][i]), i, 3*i + 6);
            end
        end
    endtask

    task automatic test_pad;
        logic [7:0] exp_d;
        fill_mem(1, 8'd1); fil_b = {3{8'd1}};
        clear_unit(1); pulse_start(1); wait_done(1, "pad");
        checks++;
        if (n_w[1] !== 8) begin errors++; $display("FAIL pad_count: got %0d, required 8", n_w[1]); end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i == 0 || i == 7) ? 8'd2 : 8'd3;
            checks++;
            if (w_addr[1][i] !== 3'(i) || w_data[1][i] !== exp_d || w_lv[1][i] !== (i == 7)) begin
                errors++;
                $display("FAIL pad_write[%0d]: addr=%0d data=%0d last=%b, required addr=%0d data=%0d last=%b",
                    i, w_addr[1][i], $signed(w_data[1][i]), w_lv[1][i], i, exp_d, (i == 7));
            end
        end
        checks++;
        if (n_rd[1] !== 8) begin errors++; $display("FAIL pad_reads: got %0d img_rden cycles, required 8", n_rd[1]); end
        checks++;
        if (done_cyc[1] !== lv_cyc[1] + 1) begin
            errors++; $display("FAIL pad_done_timing: done at %0d, required %0d", done_cyc[1], lv_cyc[1] + 1);
        end
    endtask

    task automatic test_stride;
        logic [7:0] exp_d;
        fill_mem(2, 8'd1); fil_c = {{3{8'd2}}, {3{8'd1}}};
        clear_unit(2); pulse_start(2); wait_done(2, "stride");
        checks++;
        if (n_w[2] !== 6) begin errors++; $display("FAIL stride_count: got %0d, required 6", n_w[2]); end
        for (int i = 0; i < 6; i++) begin
            exp_d = (i % 2 == 1) ? 8'd6 : 8'd3;
            checks++;
            if (w_addr[2][i] !== 3'(i) || w_data[2][i] !== exp_d) begin
                errors++;
                $display("FAIL stride_write[%0d]: addr=%0d data=%0d, required addr=%0d data=%0d",
                    i, w_addr[2][i], $signed(w_data[2][i]), i, exp_d);
            end
        end
        checks++;
        if (n_rd[2] !== 7) begin errors++; $display("FAIL stride_reads: got %0d, required 7", n_rd[2]); end
    endtask

    task automatic test_saturation;
        fill_mem(0, 8'd127); fil_a = {3{8'd127}};
        clear_unit(0); pulse_start(0); wait_done(0, "sat_pos");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL sat_pos_count: got %0d, required 6", n_w[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_data[0][i] !== 8'd127) begin
                errors++; $display("FAIL sat_pos[%0d]: got %0d, required 127", i, $signed(w_data[0][i]));
            end
        end
        fil_a = {3{8'h80}};
        clear_unit(0); pulse_start(0); wait_done(0, "sat_neg");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL sat_neg_count: got %0d, required 6", n_w[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_data[0][i] !== 8'h80) begin
                errors++; $display("FAIL sat_neg[%0d]: got %0d, required -128", i, $signed(w_data[0][i]));
            end
        end
        fill_mem(3, 8'd1); fil_d = {3{8'hFF}};
        clear_unit(3); pulse_start(3); wait_done(3, "relu");
        checks++;
        if (n_w[3] !== 6) begin errors++; $display("FAIL relu_count: got %0d, required 6", n_w[3]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_data[3][i] !== 8'd0) begin
                errors++; $display("FAIL relu_neg[%0d]: got %0d, required 0", i, $signed(w_data[3][i]));
            end
        end
        fil_d = {3{8'd1}};
        clear_unit(3); pulse_start(3); wait_done(3, "relu_pos");
        checks++;
        if (w_data[3][2] !== 8'd3) begin
            errors++; $display("FAIL relu_pos: got %0d, required 3", $signed(w_data[3][2]));
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        fill_mem(0, 8'd1); fil_a = {3{8'd1}};
        clear_unit(0); pulse_start(0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            @(negedge clk);
            if (if_a.result_wren) seen++;
        end
        rst[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_w[0] !== 3) begin errors++; $display("FAIL reset_mid_writes: got %0d, required 3", n_w[0]); end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, required 0", busy[0]); end
        clear_unit(0); pulse_start(0); wait_done(0, "reset_rerun");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL reset_rerun_count: got %0d, required 6", n_w[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w_addr[0][i] !== 3'(i) || w_data[0][i] !== 8'd3) begin
                errors++;
                $display("FAIL reset_rerun[%0d]: addr=%0d data=%0d, required addr=%0d data=3",
                    i, w_addr[0][i], $signed(w_data[0][i]), i);
            end
        end
    endtask

    task automatic test_back_to_back;
        fill_mem(0, 8'd1); fil_a = {3{8'd1}};
        clear_unit(0); pulse_start(0);
        repeat (3) @(posedge clk);
        #1 st[0] = 1'b1; @(posedge clk); #1 st[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 st[0] = 1'b1; @(posedge clk); #1 st[0] = 1'b0;
        wait_done(0, "busy_start");
        checks++;
        if (n_w[0] !== 6) begin errors++; $display("FAIL busy_start_count: got %0d, required 6", n_w[0]); end
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_w[0] !== 6 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL busy_start_quiet: writes=%0d busy=%b, required writes=6 busy=0", n_w[0], busy[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_pad();
        test_stride();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
